seq_digit_multiplier: RTL and testbench

SEQ_DIGIT_MULTIPLIER -- requirements
Module: seq_digit_multiplier

---
 rtl/seq_digit_multiplier_pkg.sv | 12 +
 rtl/digit_multiplier.sv | 13 +
 rtl/seq_digit_multiplier.sv | 103 ++++++++++
 tb/tb_seq_digit_multiplier.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_digit_multiplier_pkg.sv
// Shared definitions for the digit-serial multiplier: FSM state type and encoding width.
package seq_digit_multiplier_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/digit_multiplier.sv
// Unsigned WIDTH x DIGIT combinational multiplier producing one partial product per cycle.
module digit_multiplier #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [DIGIT-1:0]       digit,
  output logic [WIDTH+DIGIT-1:0] product
);

  assign product = (WIDTH+DIGIT)'(a) * (WIDTH+DIGIT)'(digit);

endmodule

// File: rtl/seq_digit_multiplier.sv
// Sequential sign-magnitude multiplier retiring DIGIT bits of |b| per cycle, MSB first,
// followed by a sign-fix cycle; result is ready N+1 cycles after start.
module seq_digit_multiplier #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);
  import seq_digit_multiplier_pkg::*;

  if (DIGIT < 1 || WIDTH < DIGIT || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("seq_digit_multiplier: WIDTH must be a positive multiple of DIGIT");
  end

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t                   state, state_next;
  logic [WIDTH-1:0]         mag_a, mag_b;
  logic                     neg;
  logic [2*WIDTH-1:0]       acc, acc_next;
  logic [CNT_W-1:0]         cnt;
  logic [WIDTH+DIGIT-1:0]   partial;
  logic [WIDTH-1:0]         abs_a, abs_b;
  logic                     last_digit;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign abs_a      = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign abs_b      = (signed_mode && b[WIDTH-1]) ? -b : b;
  assign last_digit = (cnt == CNT_W'(N - 1));
  assign busy       = (state != IDLE);

  digit_multiplier #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) u_digit (
    .a       (mag_a),
    .digit   (mag_b[WIDTH-1 -: DIGIT]),
    .product (partial)
  );

  assign acc_next = (acc << DIGIT) + (2*WIDTH)'(partial);

  always_comb begin
    // NOTE: default assigned before the case so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_digit) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
    if (rst) begin
      mag_a <= '0;
      mag_b <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      out   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          mag_a <= abs_a;
          mag_b <= abs_b;
          neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc   <= '0;
          cnt   <= '0;
        end
        RUN: begin
          acc   <= acc_next;
          mag_b <= mag_b << DIGIT;
          cnt   <= cnt + CNT_W'(1);
        end
        FIX: begin
          // Two's-complement negation of zero is zero, so a zero product never comes out as -0.
          out  <= neg ? -acc : acc;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_digit_multiplier.sv
// Self-checking bench: three configurations (8/2, 16/4, 8/1) against an integer product model.
module tb_seq_digit_multiplier;

  logic clk = 1'b0;
  logic rst;

  logic        start0, sm0, busy0, done0;
  logic [7:0]  a0, b0;
  logic [15:0] out0;
  logic        start1, sm1, busy1, done1;
  logic [15:0] a1, b1;
  logic [31:0] out1;
  logic        start2, sm2, busy2, done2;
  logic [7:0]  a2, b2;
  logic [15:0] out2;

  always #5 clk = ~clk;

  seq_digit_multiplier #(.WIDTH(8), .DIGIT(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .signed_mode(sm0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .out(out0));
  seq_digit_multiplier #(.WIDTH(16), .DIGIT(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .signed_mode(sm1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .out(out1));
  seq_digit_multiplier #(.WIDTH(8), .DIGIT(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .signed_mode(sm2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .out(out2));

  int checks = 0;
  int errors = 0;
  int busy_gaps = 0;

  typedef struct {
    int          cfg;
    logic        sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int w_of(input int cfg);
    return (cfg == 1) ? 16 : 8;
  endfunction

  function automatic int n_of(input int cfg);
    return (cfg == 2) ? 8 : 4;
  endfunction

  task automatic drive(input int cfg, input logic st, input logic sm,
                       input logic [15:0] a, input logic [15:0] b);
    case (cfg)
      0:       begin start0 = st; sm0 = sm; a0 = a[7:0]; b0 = b[7:0]; end
      1:       begin start1 = st; sm1 = sm; a1 = a;      b1 = b;      end
      default: begin start2 = st; sm2 = sm; a2 = a[7:0]; b2 = b[7:0]; end
    endcase
  endtask

  function automatic logic [31:0] get_out(input int cfg);
    case (cfg)
      0:       return {16'h0, out0};
      1:       return out1;
      default: return {16'h0, out2};
    endcase
  endfunction

  function automatic logic get_done(input int cfg);
    case (cfg)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic get_busy(input int cfg);
    case (cfg)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  // Reference: interpret operands as w-bit signed/unsigned integers, multiply, keep 2w bits.
  function automatic logic [31:0] ref_prod(input int w, input logic sm,
                                           input logic [15:0] a, input logic [15:0] b);
    longint av, bv, p, mask_w;
    mask_w = (longint'(1) << w) - 1;
    av = longint'(a) & mask_w;
    bv = longint'(b) & mask_w;
    if (sm && av[w-1]) av = av - (longint'(1) << w);
    if (sm && bv[w-1]) bv = bv - (longint'(1) << w);
    p = av * bv;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Launch one operation and wait (bounded) for done; operands are scrambled after capture.
  task automatic run_op(input int cfg, input logic sm, input logic [15:0] a, input logic [15:0] b,
                        input bit immediate, output logic [31:0] res, output int lat);
    if (!immediate) @(negedge clk);
    drive(cfg, 1'b1, sm, a, b);
    @(negedge clk);
    drive(cfg, 1'b0, ~sm, ~a, ~b);
    lat = 0;
    while (!get_done(cfg) && lat < 64) begin
      if (!get_busy(cfg)) busy_gaps++;
      @(negedge clk);
      lat++;
    end
    res = get_out(cfg);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[10];
    logic [31:0] res;
    int          lat;
    int          done_cnt, first_t, t;

    vecs[0] = '{0, 1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01};
    vecs[1] = '{0, 1'b1, 16'h0080, 16'h0080, 32'h00004000};
    vecs[2] = '{0, 1'b1, 16'h00FD, 16'h0005, 32'h0000FFF1};
    vecs[3] = '{0, 1'b1, 16'h0000, 16'h00F9, 32'h00000000};
    vecs[4] = '{0, 1'b1, 16'h007F, 16'h0080, 32'h0000C080};
    vecs[5] = '{0, 1'b0, 16'h0006, 16'h0007, 32'h0000002A};
    vecs[6] = '{1, 1'b1, 16'h8000, 16'h8000, 32'h40000000};
    vecs[7] = '{1, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[8] = '{2, 1'b1, 16'h00FF, 16'h00FF, 32'h00000001};
    vecs[9] = '{2, 1'b1, 16'h00F9, 16'h0000, 32'h00000000};

    rst = 1'b1;
    for (int c = 0; c < 3; c++) drive(c, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(0, 1'b1, 1'b0, 16'd9, 16'd9);  // start during reset must lose to rst
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("reset_out%0d", c),  get_out(c), 32'h0);
      check($sformatf("reset_busy%0d", c), 32'(get_busy(c)), 32'h0);
      check($sformatf("reset_done%0d", c), 32'(get_done(c)), 32'h0);
    end
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].cfg, vecs[i].sm, vecs[i].a, vecs[i].b, 1'b0, res, lat);
      check($sformatf("vec%0d_out", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(n_of(vecs[i].cfg) + 1));
      check($sformatf("vec%0d_busy_at_done", i), 32'(get_busy(vecs[i].cfg)), 32'h0);
    end

    // Start while busy with different operands: ignored, single done, original product.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'd13, 16'd11);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'd99, 16'd99);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'd200, 16'd200);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
    t = 2;
    done_cnt = 0;
    first_t = -1;
    res = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      t++;
      if (get_done(0)) begin
        done_cnt++;
        if (done_cnt == 1) begin
          first_t = t;
          res = get_out(0);
        end
      end
    end
    check("busy_start_out", res, 32'd143);
    check("busy_start_latency", 32'(first_t), 32'd5);
    check("busy_start_done_count", 32'(done_cnt), 32'd1);

    // Reset asserted during the second RUN cycle discards the operation.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'd100, 16'd100);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_busy", 32'(busy0), 32'h0);
    check("midrun_rst_done", 32'(done0), 32'h0);
    check("midrun_rst_out",  32'(out0),  32'h0);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done0) done_cnt++;
    end
    check("midrun_rst_no_done", 32'(done_cnt), 32'h0);
    run_op(0, 1'b0, 16'd6, 16'd7, 1'b0, res, lat);
    check("after_rst_out", res, 32'd42);
    check("after_rst_latency", 32'(lat), 32'd5);
    repeat (3) @(negedge clk);
    check("out_holds", 32'(out0), 32'd42);

    // Back-to-back: second start issued in the done cycle.
    run_op(0, 1'b1, 16'hFFFD, 16'h0005, 1'b0, res, lat);
    check("b2b_first_out", res, 32'h0000FFF1);
    check("b2b_first_latency", 32'(lat), 32'd5);
    run_op(0, 1'b0, 16'd200, 16'd3, 1'b1, res, lat);
    check("b2b_second_out", res, 32'd600);
    check("b2b_second_latency", 32'(lat), 32'd5);

    // Randomized operands in both modes for the 16/4 and 8/1 configurations.
    for (int c = 1; c < 3; c++) begin
      for (int i = 0; i < 1000; i++) begin
        logic [15:0] ra, rb;
        logic        rsm;
        ra  = 16'($urandom);
        rb  = 16'($urandom);
        rsm = 1'($urandom_range(0, 1));
        if (i % 50 == 0) ra = (w_of(c) == 16) ? 16'h8000 : 16'h0080;
        if (i % 70 == 1) rb = 16'h0000;
        run_op(c, rsm, ra, rb, 1'b0, res, lat);
        check($sformatf("rand%0d_%0d_out a=%0h b=%0h sm=%0b", c, i, ra, rb, rsm),
              res, ref_prod(w_of(c), rsm, ra, rb));
        check($sformatf("rand%0d_%0d_latency", c, i), 32'(lat), 32'(n_of(c) + 1));
      end
    end

    check("busy_low_while_in_flight", 32'(busy_gaps), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
